// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Used by the fetch unit, its FIFO and the bus interface.
package fetch_unit_pkg;

    localparam int WORDSIZE      = 32;
    localparam int FETCH_ENTRY_W = 2 * WORDSIZE;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [WORDSIZE-1:0] instr;
        logic [WORDSIZE-1:0] pc;
    } fetch_entry_t;

    // ROM is word addressed; the two byte-offset bits of the PC are dropped.
    function automatic logic [WORDSIZE-1:0] word_index(input logic [WORDSIZE-1:0] byte_pc);
        return byte_pc >> 2;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch unit and its surroundings (ROM, decode, control).
// The master modport is the fetch unit's view; slave is the environment's view.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic [WORDSIZE-1:0] rom_addr;
    logic [WORDSIZE-1:0] rom_data;
    logic                if_valid;
    logic                if_ready;
    logic [WORDSIZE-1:0] if_instr;
    logic [WORDSIZE-1:0] if_pc;
    logic                redirect_valid;
    logic [WORDSIZE-1:0] redirect_pc;
    logic                halt;

    modport master (
        output rom_addr, if_valid, if_instr, if_pc,
        input  rom_data, if_ready, redirect_valid, redirect_pc, halt
    );

    modport slave (
        input  rom_addr, if_valid, if_instr, if_pc,
        output rom_data, if_ready, redirect_valid, redirect_pc, halt
    );

endinterface

// File: rtl/fetch_unit_fifo.sv
// Small circular FIFO holding fetched {instr, pc} entries ahead of decode.
// Flush beats push; push while full is accepted only together with a pop.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 64
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic                       head_valid,
    output logic [W-1:0]               head_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_q;
    logic [PW-1:0] wr_q;
    logic [CW-1:0] count_q;
    logic          do_pop;
    logic          do_push;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);

    always_ff @(posedge CLK) begin
        if (reset || flush) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= next_ptr(wr_q);
            end
            if (do_pop) begin
                rd_q <= next_ptr(rd_q);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset && !flush && do_push) begin
            mem_q[wr_q] <= push_data;
        end
    end

    // An empty FIFO presents zeros so decode never sees a stale word.
    assign head_valid = (count_q != '0);
    assign head_data  = head_valid ? mem_q[rd_q] : '0;
    assign count      = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues ROM reads and turns the registered
// ROM data into a PC-tagged valid/ready stream, with redirect, halt and credit-based flow control.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [WORDSIZE-1:0] RESET_PC = 32'h0000_0000,
    parameter int                  DEPTH    = 2
) (
    input  logic          CLK,
    input  logic          reset,
    fetch_unit_if.master  bus
);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_e        state_q, state_d;
    logic [WORDSIZE-1:0] pc_q, pc_d;
    logic                inflight_q, inflight_d;
    logic [WORDSIZE-1:0] inflight_pc_q, inflight_pc_d;

    logic                pop;
    logic                push;
    logic                issue;
    logic [CW:0]         pending;
    logic [CW-1:0]       fifo_count;
    logic                head_valid;
    fetch_entry_t        head_entry;
    fetch_entry_t        push_entry;

    assign pop  = head_valid && bus.if_ready;
    assign push = inflight_q && !bus.redirect_valid;

    // Entries that will occupy the FIFO once the current cycle retires; issuing only
    // below DEPTH guarantees the returning word always has a slot.
    assign pending = (CW+1)'(fifo_count) + (CW+1)'(inflight_q) - (CW+1)'(pop);
    assign issue   = (state_q != ST_HALT) && !bus.halt && !bus.redirect_valid
                     && (pending < (CW+1)'(DEPTH));

    assign push_entry.instr = bus.rom_data;
    assign push_entry.pc    = inflight_pc_q;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (FETCH_ENTRY_W)
    ) u_fifo (
        .CLK        (CLK),
        .reset      (reset),
        .flush      (bus.redirect_valid),
        .push       (push),
        .push_data  (push_entry),
        .pop        (pop),
        .head_valid (head_valid),
        .head_data  (head_entry),
        .count      (fifo_count)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;

        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  if (bus.halt && !bus.redirect_valid) state_d = ST_HALT;
            ST_HALT: if (!bus.halt) state_d = ST_RUN;
            default: state_d = ST_BOOT;
        endcase

        if (bus.redirect_valid) begin
            pc_d = bus.redirect_pc & ~32'h3;
        end else if (issue) begin
            pc_d          = pc_q + 32'd4;
            inflight_pc_d = pc_q;
        end
    end

    assign bus.rom_addr = word_index(pc_q);
    assign bus.if_valid = head_valid;
    assign bus.if_instr = head_entry.instr;
    assign bus.if_pc    = head_entry.pc;

endmodule
